// File: rtl/ercm8_dot_acc.sv
// Saturating dot-product accumulator for the ERCM8 approximate-multiplier pipeline.
// Sums len unsigned 16-bit products into an ACC_W-bit result with a sticky saturation flag.
module ercm8_dot_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             prod_vld,
  input  logic [15:0]      prod_dat,
  output logic             prod_rdy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [ACC_W-1:0] res_dat,
  output logic             res_sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_q;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic             xfer;
  logic             last_xfer;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_nxt;

  assign xfer      = (state == ACC) && prod_vld;
  assign last_xfer = xfer && (cnt == CNT_W'(1));

  // One extra bit catches the carry; once at ACC_MAX, sum stays >= ACC_MAX so no wrap.
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(prod_dat);
  assign ovf     = sum[ACC_W];
  assign acc_nxt = ovf ? ACC_MAX : sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? HOLD : ACC;
      ACC:  if (last_xfer) state_nxt = HOLD;
      HOLD: if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // res_q is a separate result register so res_dat does not follow acc while a new sum builds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      res_q <= '0;
    end else begin
      // NOTE: non-blocking so every register here sees the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            sat <= 1'b0;
            cnt <= len;
            if (len == '0) res_q <= '0;
          end
        end
        ACC: begin
          if (xfer) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (ovf) sat <= 1'b1;
            if (last_xfer) res_q <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign prod_rdy = (state == ACC);
  assign res_vld  = (state == HOLD);
  assign busy     = (state != IDLE);
  assign res_dat  = res_q;
  assign res_sat  = sat;

endmodule

// File: doc/ercm8_dot_acc.md
ERCM8_DOT_ACC -- requirements
Module: ercm8_dot_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator and result width (legal range 16..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the product-count field.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a new dot product; sampled only in IDLE.
REQ-006 SHALL have port len  input  CNT_W  number of products to accumulate; sampled with start.
REQ-007 SHALL have port prod_vld  input  1  upstream 8x8 approximate-multiplier product valid.
REQ-008 SHALL have port prod_dat  input  16  unsigned product from the ERCM8 multiplier stage.
REQ-009 SHALL have port prod_rdy  output  1  block accepts prod_dat this cycle.
REQ-010 SHALL have port res_vld  output  1  final result available.
REQ-011 SHALL have port res_rdy  input  1  downstream accepts the result.
REQ-012 SHALL have port res_dat  output  ACC_W  unsigned accumulated sum.
REQ-013 SHALL have port res_sat  output  1  saturation occurred during this dot product.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACC, HOLD; outputs decoded from registered state only.
REQ-016 In IDLE, start=1 and len!=0 SHALL clear acc and res_sat, load cnt=len, go to ACC next cycle.
REQ-017 In IDLE, start=1 and len==0 SHALL clear acc and res_sat and go directly to HOLD (result 0).
REQ-018 start SHALL be ignored in ACC and HOLD; len SHALL have no effect except when sampled per REQ-016/017.
REQ-019 prod_rdy SHALL equal 1 in ACC and 0 in IDLE and HOLD.
REQ-020 A transfer SHALL occur on a cycle with prod_vld=1 and prod_rdy=1; prod_dat is ignored otherwise.
REQ-021 On each transfer acc SHALL become acc + zero-extended prod_dat, computed at ACC_W+1 bits.
REQ-022 If that sum exceeds 2^ACC_W-1, acc SHALL become 2^ACC_W-1 and res_sat SHALL be set, sticky until next start.
REQ-023 Once saturated, further transfers SHALL keep acc at 2^ACC_W-1 (no wrap-around).
REQ-024 Each transfer SHALL decrement cnt; the transfer with cnt==1 SHALL move the FSM to HOLD.
REQ-025 prod_vld low cycles in ACC SHALL stall without changing acc or cnt.
REQ-026 res_vld SHALL be 1 exactly in HOLD; res_dat and res_sat SHALL equal acc and sticky flag and stay stable while res_vld=1.
REQ-027 Latency: res_vld SHALL rise on the cycle after the final transfer (or after start with len==0).
REQ-028 In HOLD, res_rdy=1 SHALL return the FSM to IDLE next cycle; res_rdy=0 SHALL hold indefinitely.
REQ-029 A start asserted on the same cycle as the HOLD->IDLE handshake SHALL be ignored (FSM not in IDLE).
REQ-030 res_dat SHALL retain its last value in IDLE and ACC; only res_vld qualifies it.
REQ-031 The block SHALL be fully synchronous apart from rst; no combinational path from prod_vld or res_rdy to any output.

Reset
REQ-032 rst=1 SHALL asynchronously force state=IDLE, acc=0, cnt=0, res_sat=0.
REQ-033 During and after reset SHALL hold prod_rdy=0, res_vld=0, busy=0, res_dat=0, res_sat=0.
REQ-034 Reset asserted mid-ACC or mid-HOLD SHALL discard the partial/pending result; no res_vld after deassertion until a new start completes.

Verification
REQ-035 start, len=3; products 100, 200, 300 back-to-back -> res_vld 1 cycle after third transfer, res_dat=600, res_sat=0.
REQ-036 start, len=2; prod_vld toggled 1,0,0,1 with 65025 both transfers -> res_dat=130050; idle cycles leave acc unchanged.
REQ-037 start, len=0 -> res_vld next cycle, res_dat=0, prod_rdy never asserted.
REQ-038 ACC_W=16, len=3, products 65535, 2, 7 -> res_dat=65535, res_sat=1; next start clears res_sat.
REQ-039 res_rdy held 0 for 10 cycles in HOLD with start pulsed -> res_dat stable, start ignored; res_rdy=1 -> IDLE next cycle.
REQ-040 rst pulsed after 1 of 4 transfers -> all outputs 0 immediately; new start, len=1, product 5 -> res_dat=5.
